// File: rtl/sc_comp_dataflow.sv
`default_nettype none
// ============================================================================
//  Module      : sc_comp_dataflow
//  Description : Single-cycle MIPS-32 computer. CPU core, instruction ROM,
//                data RAM and a 32x32 register file; every rising clock
//                edge retires exactly one instruction.
//  Ports       : clk   - system clock, all state commits on the rising edge
//                reset - synchronous, active-high; pc <- 0x0040_0000,
//                        registers <- 0, no memory write on that edge
//                pc    - address of the instruction being executed
//                inst  - instruction word fetched at pc (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_comp_dataflow (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    localparam logic [31:0] c_TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] c_DATA_BASE  = 32'h1001_0000;
    localparam int          c_IMEM_WORDS = 8192;
    localparam int          c_DMEM_WORDS = 2048;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0a;
    localparam logic [5:0] c_OP_SLTIU = 6'h0b;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_XORI  = 6'h0e;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_SLLV = 6'h04;
    localparam logic [5:0] c_FN_SRLV = 6'h06;
    localparam logic [5:0] c_FN_SRAV = 6'h07;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2a;
    localparam logic [5:0] c_FN_SLTU = 6'h2b;

    // Instruction ROM: contents are preloaded from outside, never written here.
    logic [31:0] r_imem [0:c_IMEM_WORDS-1];
    logic [31:0] r_dmem [0:c_DMEM_WORDS-1];
    // Kept as a plain indexable array so individual entries can be observed.
    logic [31:0] r_regs [0:31];
    logic [31:0] r_pc;

    // ---------------- fetch ----------------
    logic [31:0] w_pc_off;
    logic [31:0] w_pc_plus4;
    assign w_pc_off   = r_pc - c_TEXT_BASE;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign pc         = r_pc;
    // Anything past the last ROM word (or below the text base, which wraps
    // to a huge offset) fetches a nop.
    assign inst = (w_pc_off[31:15] == 17'd0) ? r_imem[w_pc_off[14:2]] : 32'h0;

    // ---------------- decode / operands ----------------
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_sh_amt;
    logic [31:0] w_rs_val, w_rt_val, w_imm_sext, w_imm_zext, w_alu_b;
    assign w_op       = inst[31:26];
    assign w_rs       = inst[25:21];
    assign w_rt       = inst[20:16];
    assign w_rd       = inst[15:11];
    assign w_shamt    = inst[10:6];
    assign w_funct    = inst[5:0];
    assign w_rs_val   = r_regs[w_rs];
    assign w_rt_val   = r_regs[w_rt];
    assign w_imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign w_imm_zext = {16'h0, inst[15:0]};
    // R-type uses rt as second operand; every I-type consumer takes sext(imm).
    assign w_alu_b    = (w_op == c_OP_RTYPE) ? w_rt_val : w_imm_sext;
    // funct[2] distinguishes variable shifts (sllv/srlv/srav) from shamt forms.
    assign w_sh_amt   = w_funct[2] ? w_rs_val[4:0] : w_shamt;

    // ---------------- shared datapath ----------------
    logic [31:0] w_sum, w_diff;
    logic        w_sum_ovf, w_diff_ovf, w_lt_s, w_lt_u;
    assign w_sum      = w_rs_val + w_alu_b;
    assign w_diff     = w_rs_val - w_rt_val;
    assign w_sum_ovf  = (w_rs_val[31] == w_alu_b[31]) && (w_sum[31] != w_rs_val[31]);
    assign w_diff_ovf = (w_rs_val[31] != w_rt_val[31]) && (w_diff[31] != w_rs_val[31]);
    assign w_lt_s     = $signed(w_rs_val) < $signed(w_alu_b);
    assign w_lt_u     = w_rs_val < w_alu_b;

    // Effective data address is rs + sext(imm), i.e. the shared adder.
    logic [31:0] w_dmem_off;
    logic [10:0] w_dmem_idx;
    assign w_dmem_off = w_sum - c_DATA_BASE;
    assign w_dmem_idx = w_dmem_off[12:2];

    logic [31:0] w_br_target, w_j_target;
    assign w_br_target = w_pc_plus4 + (w_imm_sext << 2);
    assign w_j_target  = {w_pc_plus4[31:28], inst[25:0], 2'b00};

    // Address bits discarded by word indexing / wrap-around truncation.
    logic w_unused;
    assign w_unused = ^{w_pc_off[1:0], w_dmem_off[31:13], w_dmem_off[1:0]};

    // ---------------- control ----------------
    logic [31:0] w_next_pc, w_rf_wdata;
    logic [4:0]  w_rf_waddr;
    logic        w_rf_we, w_dmem_we;

    always_comb begin
        w_next_pc  = w_pc_plus4;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rt;
        w_rf_wdata = 32'h0;
        w_dmem_we  = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
                case (w_funct)
                    c_FN_ADD:  begin w_rf_wdata = w_sum;  w_rf_we = !w_sum_ovf;  end
                    c_FN_ADDU: w_rf_wdata = w_sum;
                    c_FN_SUB:  begin w_rf_wdata = w_diff; w_rf_we = !w_diff_ovf; end
                    c_FN_SUBU: w_rf_wdata = w_diff;
                    c_FN_AND:  w_rf_wdata = w_rs_val & w_rt_val;
                    c_FN_OR:   w_rf_wdata = w_rs_val | w_rt_val;
                    c_FN_XOR:  w_rf_wdata = w_rs_val ^ w_rt_val;
                    c_FN_NOR:  w_rf_wdata = ~(w_rs_val | w_rt_val);
                    c_FN_SLT:  w_rf_wdata = {31'd0, w_lt_s};
                    c_FN_SLTU: w_rf_wdata = {31'd0, w_lt_u};
                    c_FN_SLL, c_FN_SLLV: w_rf_wdata = w_rt_val << w_sh_amt;
                    c_FN_SRL, c_FN_SRLV: w_rf_wdata = w_rt_val >> w_sh_amt;
                    c_FN_SRA, c_FN_SRAV: w_rf_wdata = $signed(w_rt_val) >>> w_sh_amt;
                    c_FN_JR:   begin w_rf_we = 1'b0; w_next_pc = w_rs_val; end
                    default:   w_rf_we = 1'b0;
                endcase
            end
            c_OP_ADDI:  begin w_rf_we = !w_sum_ovf; w_rf_wdata = w_sum; end
            c_OP_ADDIU: begin w_rf_we = 1'b1; w_rf_wdata = w_sum; end
            c_OP_SLTI:  begin w_rf_we = 1'b1; w_rf_wdata = {31'd0, w_lt_s}; end
            c_OP_SLTIU: begin w_rf_we = 1'b1; w_rf_wdata = {31'd0, w_lt_u}; end
            c_OP_ANDI:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val & w_imm_zext; end
            c_OP_ORI:   begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val | w_imm_zext; end
            c_OP_XORI:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val ^ w_imm_zext; end
            c_OP_LUI:   begin w_rf_we = 1'b1; w_rf_wdata = {inst[15:0], 16'h0}; end
            c_OP_LW:    begin w_rf_we = 1'b1; w_rf_wdata = r_dmem[w_dmem_idx]; end
            c_OP_SW:    w_dmem_we = 1'b1;
            c_OP_BEQ:   if (w_rs_val == w_rt_val) w_next_pc = w_br_target;
            c_OP_BNE:   if (w_rs_val != w_rt_val) w_next_pc = w_br_target;
            c_OP_J:     w_next_pc = w_j_target;
            c_OP_JAL: begin
                w_next_pc  = w_j_target;
                w_rf_we    = 1'b1;
                w_rf_waddr = 5'd31;
                w_rf_wdata = w_pc_plus4;
            end
            default: ;
        endcase
    end

    // ---------------- architectural state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= c_TEXT_BASE;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else begin
            r_pc <= w_next_pc;
            // $0 is hardwired: writes to it are simply dropped.
            if (w_rf_we && (w_rf_waddr != 5'd0)) r_regs[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // DMEM has no reset; reset only suppresses a store on that edge.
    always_ff @(posedge clk) begin
        if (!reset && w_dmem_we) r_dmem[w_dmem_idx] <= w_rt_val;
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_comp_dataflow.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_comp_dataflow
//  Description : Self-checking bench for sc_comp_dataflow. An instruction-set
//                model steps alongside the DUT; directed programs pin known
//                results, random programs exercise the whole instruction set
//                with sporadic mid-run resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_comp_dataflow;

    localparam logic [31:0] c_TEXT = 32'h0040_0000;
    localparam logic [31:0] c_DATA = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] inst;

    sc_comp_dataflow dut (.clk(clk), .reset(reset), .pc(pc), .inst(inst));

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [31:0] m_imem [0:8191];
    logic [31:0] m_dmem [0:2047];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fetch(input logic [31:0] a);
        logic [31:0] off;
        off = a - c_TEXT;
        if ((off >> 2) >= 32'd8192) return 32'h0;
        return m_imem[off[14:2]];
    endfunction

    function automatic int m_didx(input logic [31:0] a);
        return int'(((a - c_DATA) >> 2) & 32'h7FF);
    endfunction

    function automatic bit fits32(input longint s);
        return (s <= longint'(32'sh7FFF_FFFF)) && (s >= -longint'(32'sh7FFF_FFFF) - 1);
    endfunction

    // One architectural step, written from the instruction-set rules.
    task automatic m_step();
        logic [31:0] w, a, b, res, nxt, imm_s, imm_z;
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh, dst;
        bit          wr;
        if (reset) begin
            m_pc = c_TEXT;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            return;
        end
        w  = m_fetch(m_pc);
        op = w[31:26]; fn = w[5:0];
        rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]); sh = int'(w[10:6]);
        a  = m_regs[rs]; b = m_regs[rt];
        imm_s = {{16{w[15]}}, w[15:0]};
        imm_z = {16'h0, w[15:0]};
        nxt = m_pc + 32'd4; wr = 1'b0; dst = rt; res = 32'h0;
        case (op)
            6'h00: begin
                dst = rd; wr = 1'b1;
                case (fn)
                    6'h20: begin res = a + b; wr = fits32(longint'($signed(a)) + longint'($signed(b))); end
                    6'h21: res = a + b;
                    6'h22: begin res = a - b; wr = fits32(longint'($signed(a)) - longint'($signed(b))); end
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2b: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h04: res = b << a[4:0];
                    6'h06: res = b >> a[4:0];
                    6'h07: res = $signed(b) >>> a[4:0];
                    6'h08: begin wr = 1'b0; nxt = a; end
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin res = a + imm_s; wr = fits32(longint'($signed(a)) + longint'($signed(imm_s))); end
            6'h09: begin res = a + imm_s; wr = 1'b1; end
            6'h0a: begin res = ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0; wr = 1'b1; end
            6'h0b: begin res = (a < imm_s) ? 32'd1 : 32'd0; wr = 1'b1; end
            6'h0c: begin res = a & imm_z; wr = 1'b1; end
            6'h0d: begin res = a | imm_z; wr = 1'b1; end
            6'h0e: begin res = a ^ imm_z; wr = 1'b1; end
            6'h0f: begin res = {w[15:0], 16'h0}; wr = 1'b1; end
            6'h23: begin res = m_dmem[m_didx(a + imm_s)]; wr = 1'b1; end
            6'h2b: m_dmem[m_didx(a + imm_s)] = b;
            6'h04: if (a == b) nxt = m_pc + 32'd4 + (imm_s << 2);
            6'h05: if (a != b) nxt = m_pc + 32'd4 + (imm_s << 2);
            6'h02: nxt = {nxt[31:28], w[25:0], 2'b00};
            6'h03: begin
                res = m_pc + 32'd4; dst = 31; wr = 1'b1;
                nxt = {nxt[31:28], w[25:0], 2'b00};
            end
            default: ;
        endcase
        if (wr && dst != 0) m_regs[dst] = res;
        m_pc = nxt;
    endtask

    always @(posedge clk) m_step();

    // Compare process: every cycle once a program is running.
    always @(negedge clk) begin
        if (check_en) begin
            int bi, bd;
            cmp("pc", pc, m_pc);
            cmp("inst", inst, m_fetch(m_pc));
            bi = 0;
            for (int i = 31; i >= 0; i--) if (dut.r_regs[i] !== m_regs[i]) bi = i;
            cmp($sformatf("reg[%0d]", bi), dut.r_regs[bi], m_regs[bi]);
            bd = 0;
            for (int i = 2047; i >= 0; i--) if (dut.r_dmem[i] !== m_dmem[i]) bd = i;
            cmp($sformatf("dmem[%0d]", bd), dut.r_dmem[bd], m_dmem[bd]);
        end
    end

    // ---------------- encoders / helpers ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
        return {op, addr[27:2]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        m_imem[idx]     = w;
        dut.r_imem[idx] = w;
    endtask

    // Stop checking, hold reset and wipe both memories (DUT and model).
    task automatic prepare();
        check_en = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 8192; i++) put(i, 32'h0);
        for (int i = 0; i < 2048; i++) begin
            m_dmem[i]     = 32'h0;
            dut.r_dmem[i] = 32'h0;
        end
    endtask

    task automatic start();
        tick(1);
        reset    = 1'b0;
        check_en = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [5:0] iops [8] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
        int k, rs, rt, rd, off;
        logic [15:0] imm;
        k   = int'($urandom_range(0, 40));
        rs  = int'($urandom_range(0, 15));
        rt  = int'($urandom_range(0, 15));
        rd  = int'($urandom_range(0, 15));
        imm = 16'($urandom);
        off = int'($urandom_range(0, 12)) - 6;
        if (k < 16)  return enc_r(rs, rt, rd, int'($urandom_range(0, 31)), fns[k]);
        if (k < 24)  return enc_i(iops[k-16], rs, rt, imm);
        case (k)
            24: return enc_i(6'h23, rs, rt, imm);
            25: return enc_i(6'h2b, rs, rt, imm);
            26: return enc_i(6'h04, rs, rt, 16'(off));
            27: return enc_i(6'h05, rs, rt, 16'(off));
            28: return enc_j(6'h02, c_TEXT + 32'(4 * $urandom_range(0, 254)));
            29: return enc_j(6'h03, c_TEXT + 32'(4 * $urandom_range(0, 254)));
            30: return enc_r(31, 0, 0, 0, 6'h08);
            31: return {6'h3f, 26'($urandom)};
            32: return enc_r(rs, rt, rd, 0, 6'h01);
            33, 34, 35, 36: return enc_i(6'h0f, 0, rt, imm);
            37, 38: return enc_r(rs, rt, rd, 0, 6'h20);
            default: return enc_r(rs, rt, rd, 0, 6'h22);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int nz;

        // ---- directed program 1: arithmetic, shifts, memory, control ----
        prepare();
        put(0,  enc_i(6'h08, 0, 1, 16'd5));          // addi $1,$0,5
        put(1,  enc_i(6'h08, 1, 2, 16'hFFFF));       // addi $2,$1,-1
        put(2,  enc_i(6'h0f, 0, 3, 16'h8000));       // lui  $3,0x8000
        put(3,  enc_i(6'h08, 3, 4, 16'hFFFF));       // addi $4,$3,-1 (overflow)
        put(4,  enc_i(6'h09, 3, 5, 16'hFFFF));       // addiu $5,$3,-1
        put(5,  enc_i(6'h0d, 0, 6, 16'hF0F0));       // ori  $6,$0,0xF0F0
        put(6,  enc_r(0, 3, 7, 4, 6'h03));           // sra  $7,$3,4
        put(7,  enc_r(0, 3, 8, 4, 6'h02));           // srl  $8,$3,4
        put(8,  enc_r(6, 3, 9, 0, 6'h2b));           // sltu $9,$6,$3
        put(9,  enc_r(6, 3, 10, 0, 6'h2a));          // slt  $10,$6,$3
        put(10, enc_i(6'h0f, 0, 11, 16'h1001));      // lui  $11,0x1001
        put(11, enc_i(6'h2b, 11, 6, 16'd8));         // sw   $6,8($11)
        put(12, enc_i(6'h23, 11, 12, 16'd8));        // lw   $12,8($11)
        put(13, enc_i(6'h04, 0, 0, 16'd2));          // beq  $0,$0,+2 -> word 16
        put(14, enc_i(6'h08, 0, 13, 16'd1));         // skipped
        put(15, enc_i(6'h08, 0, 13, 16'd2));         // skipped
        put(16, enc_i(6'h05, 0, 0, 16'd5));          // bne  $0,$0 (not taken)
        put(17, enc_i(6'h08, 0, 0, 16'd7));          // addi $0,$0,7
        put(18, enc_j(6'h03, 32'h0040_0100));        // jal  0x00400100
        put(19, enc_j(6'h02, 32'h0040_004C));        // j .
        put(64, enc_i(6'h08, 0, 14, 16'd9));         // addi $14,$0,9
        put(65, enc_r(31, 0, 0, 0, 6'h08));          // jr   $31
        start();

        cmp("p1 reset pc", pc, c_TEXT);
        tick(2);
        cmp("p1 pc after 2", pc, 32'h0040_0008);
        cmp("p1 $1", dut.r_regs[1], 32'd5);
        cmp("p1 $2", dut.r_regs[2], 32'd4);
        cmp("model $2", m_regs[2], 32'd4);

        tick(23);
        cmp("p1 $3 lui",      dut.r_regs[3],  32'h8000_0000);
        cmp("p1 $4 ovf",      dut.r_regs[4],  32'h0);
        cmp("model $4 ovf",   m_regs[4],      32'h0);
        cmp("p1 $5 addiu",    dut.r_regs[5],  32'h7FFF_FFFF);
        cmp("p1 $6 ori",      dut.r_regs[6],  32'h0000_F0F0);
        cmp("p1 $7 sra",      dut.r_regs[7],  32'hF800_0000);
        cmp("model $7 sra",   m_regs[7],      32'hF800_0000);
        cmp("p1 $8 srl",      dut.r_regs[8],  32'h0800_0000);
        cmp("p1 $9 sltu",     dut.r_regs[9],  32'd1);
        cmp("p1 $10 slt",     dut.r_regs[10], 32'd0);
        cmp("p1 $12 lw",      dut.r_regs[12], 32'h0000_F0F0);
        cmp("model $12 lw",   m_regs[12],     32'h0000_F0F0);
        cmp("p1 dmem[2]",     dut.r_dmem[2],  32'h0000_F0F0);
        cmp("p1 $13 skipped", dut.r_regs[13], 32'h0);
        cmp("p1 $0",          dut.r_regs[0],  32'h0);
        cmp("p1 $14",         dut.r_regs[14], 32'd9);
        cmp("p1 $31 jal",     dut.r_regs[31], 32'h0040_004C);
        cmp("model $31",      m_regs[31],     32'h0040_004C);
        cmp("p1 self-loop pc", pc,            32'h0040_004C);
        cmp("model pc",       m_pc,           32'h0040_004C);

        // Mid-run reset: pc back to base, registers cleared, DMEM kept.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        cmp("mid reset pc", pc, c_TEXT);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.r_regs[i] !== 32'h0) nz++;
        cmp("mid reset nonzero regs", 32'(nz), 32'd0);
        cmp("mid reset dmem kept", dut.r_dmem[2], 32'h0000_F0F0);
        tick(3);

        // ---- directed program 2: branch / jump addresses ----
        prepare();
        put(0,  enc_i(6'h04, 0, 0, 16'd2));          // beq $0,$0,+2
        put(3,  enc_i(6'h05, 0, 0, 16'd4));          // bne $0,$0 (not taken)
        put(4,  enc_j(6'h03, 32'h0040_0100));        // jal 0x00400100 from 0x00400010
        put(5,  enc_j(6'h02, 32'h0040_0014));        // j .
        put(64, enc_r(31, 0, 0, 0, 6'h08));          // jr $31
        start();
        tick(1);
        cmp("p2 beq target", pc, 32'h0040_000C);
        tick(1);
        cmp("p2 bne fallthrough", pc, 32'h0040_0010);
        tick(1);
        cmp("p2 jal target", pc, 32'h0040_0100);
        cmp("p2 $31", dut.r_regs[31], 32'h0040_0014);
        tick(1);
        cmp("p2 jr", pc, 32'h0040_0014);
        tick(2);
        cmp("p2 self-loop", pc, 32'h0040_0014);

        // ---- random programs with sporadic resets ----
        for (int r = 0; r < 3; r++) begin
            prepare();
            for (int i = 0; i < 255; i++) put(i, rand_inst());
            put(255, enc_j(6'h02, c_TEXT));
            start();
            for (int c = 0; c < 500; c++) begin
                reset = ($urandom_range(0, 99) == 0);
                tick(1);
            end
            reset = 1'b0;
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
